// File: rtl/uart_tx_fifo_ctrl.sv
// Byte FIFO and frame sequencer feeding a UART transmitter: buffers pushed bytes,
// launches each with a one-cycle tx_start, and waits for the done tick (with optional watchdog).
module uart_tx_fifo_ctrl #(
  parameter int DBIT    = 8,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DBIT-1:0]   w_data,
  input  logic              ovf_clr,
  input  logic              tx_done_tick,
  output logic              tx_start,
  output logic [DBIT-1:0]   tx_din,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              busy,
  output logic              overflow,
  output logic              timeout_err
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WCNT_W-1:0] WCNT_MAX  = {WCNT_W{1'b1}};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [DBIT-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;
  logic [0:0]        r_state;
  logic              r_busy;
  logic              r_tx_start;
  logic [DBIT-1:0]   r_tx_din;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_timeout_err;

  logic              w_push;
  logic              w_pop;
  logic              w_wd_fire;
  logic [ADDR_W:0]   w_count_nxt;

  // full is the registered flag, so a push into a full FIFO is rejected even when a pop coincides
  assign w_push = wr && !r_full;
  assign w_pop  = (r_state == ST_IDLE) && !r_empty;

  assign w_wd_fire = (TIMEOUT > 0) && (r_state == ST_WAIT) && !tx_done_tick &&
                     (r_wcnt == WCNT_LAST);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage is not reset; resetting the pointers and count discards its contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0);
      if (wr && r_full)  r_overflow <= 1'b1;
      else if (ovf_clr)  r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_din      <= '0;
      r_wcnt        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!r_empty) begin
            r_tx_din   <= r_mem[r_rd_ptr];
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
            r_wcnt     <= '0;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (tx_done_tick) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_wd_fire) begin
            // the in-flight byte is abandoned; the next queued byte launches from IDLE
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end else if ((TIMEOUT > 0) && (r_wcnt != WCNT_MAX)) begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_start    = r_tx_start;
  assign tx_din      = r_tx_din;
  assign full        = r_full;
  assign empty       = r_empty;
  assign level       = r_count;
  assign busy        = r_busy;
  assign overflow    = r_overflow;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl: reset, single frame, back-to-back frames,
// overflow handling, simultaneous push/pop on full, and watchdog abort.
module tb_uart_tx_fifo_ctrl;

  localparam int DBIT    = 8;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 50;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr;
  logic [DBIT-1:0]   w_data;
  logic              ovf_clr;
  logic              tx_done_tick;
  logic              tx_start;
  logic [DBIT-1:0]   tx_din;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              busy;
  logic              overflow;
  logic              timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_fifo_ctrl #(.DBIT(DBIT), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .w_data(w_data), .ovf_clr(ovf_clr),
    .tx_done_tick(tx_done_tick), .tx_start(tx_start), .tx_din(tx_din), .full(full),
    .empty(empty), .level(level), .busy(busy), .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr = 1'b1; w_data = 8'h55; ovf_clr = 1'b0; tx_done_tick = 1'b0;
    repeat (3) tick();
    n_checks++; if (tx_start !== 1'b0) $display("FAIL rst_tx_start got %0b want 0", tx_start); else n_pass++;
    n_checks++; if (tx_din !== 8'h00) $display("FAIL rst_tx_din got %h want 00", tx_din); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL rst_full got %0b want 0", full); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL rst_empty got %0b want 1", empty); else n_pass++;
    n_checks++; if (level !== 5'd0) $display("FAIL rst_level got %0d want 0", level); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow got %0b want 0", overflow); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout got %0b want 0", timeout_err); else n_pass++;
    wr = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++; if (empty !== 1'b1) $display("FAIL rst_release_empty got %0b want 1", empty); else n_pass++;
  endtask

  task automatic test_single();
    wr = 1'b1; w_data = 8'h41;
    tick();
    wr = 1'b0;
    n_checks++; if (empty !== 1'b0) $display("FAIL single_e0_empty got %0b want 0", empty); else n_pass++;
    n_checks++; if (level !== 5'd1) $display("FAIL single_e0_level got %0d want 1", level); else n_pass++;
    n_checks++; if (tx_start !== 1'b0) $display("FAIL single_e0_start got %0b want 0", tx_start); else n_pass++;
    tick();
    n_checks++; if (tx_start !== 1'b1) $display("FAIL single_e1_start got %0b want 1", tx_start); else n_pass++;
    n_checks++; if (tx_din !== 8'h41) $display("FAIL single_e1_din got %h want 41", tx_din); else n_pass++;
    n_checks++; if (level !== 5'd0) $display("FAIL single_e1_level got %0d want 0", level); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_e1_busy got %0b want 1", busy); else n_pass++;
    tick();
    n_checks++; if (tx_start !== 1'b0) $display("FAIL single_e2_start got %0b want 0", tx_start); else n_pass++;
    repeat (5) tick();
    n_checks++; if (tx_din !== 8'h41) $display("FAIL single_hold_din got %h want 41", tx_din); else n_pass++;
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_done_busy got %0b want 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b;
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; w_data = 8'h10 + 8'(i);
      tick();
    end
    wr = 1'b0;
    n_checks++; if (tx_din !== 8'h10) $display("FAIL b2b_first_din got %h want 10", tx_din); else n_pass++;
    n_checks++; if (level !== 5'd3) $display("FAIL b2b_level got %0d want 3", level); else n_pass++;
    for (int k = 1; k < 4; k++) begin
      repeat (18) tick();
      tx_done_tick = 1'b1;
      tick();
      tx_done_tick = 1'b0;
      n_checks++; if (tx_start !== 1'b0 || busy !== 1'b0) $display("FAIL b2b_idle_%0d got start=%0b busy=%0b want 0 0", k, tx_start, busy); else n_pass++;
      tick();
      exp_b = 8'h10 + 8'(k);
      n_checks++; if (tx_start !== 1'b1) $display("FAIL b2b_start_%0d got %0b want 1", k, tx_start); else n_pass++;
      n_checks++; if (tx_din !== exp_b) $display("FAIL b2b_din_%0d got %h want %h", k, tx_din, exp_b); else n_pass++;
      n_checks++; if (level !== 5'(3 - k)) $display("FAIL b2b_level_%0d got %0d want %0d", k, level, 3 - k); else n_pass++;
    end
    repeat (10) tick();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    tick();
    n_checks++; if (empty !== 1'b1) $display("FAIL b2b_final_empty got %0b want 1", empty); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_final_busy got %0b want 0", busy); else n_pass++;
    n_checks++; if (tx_start !== 1'b0) $display("FAIL b2b_final_start got %0b want 0", tx_start); else n_pass++;
  endtask

  task automatic test_overflow();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    wr = 1'b1; w_data = 8'hA0;
    tick();
    wr = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b1 || tx_din !== 8'hA0) $display("FAIL ovf_hold got busy=%0b din=%h want 1 a0", busy, tx_din); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; w_data = 8'hB0 + 8'(i);
      tick();
      if (i == 14) begin
        n_checks++; if (full !== 1'b0 || level !== 5'd15) $display("FAIL ovf_15 got full=%0b level=%0d want 0 15", full, level); else n_pass++;
      end
    end
    n_checks++; if (full !== 1'b1) $display("FAIL ovf_full got %0b want 1", full); else n_pass++;
    n_checks++; if (level !== 5'd16) $display("FAIL ovf_level16 got %0d want 16", level); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_pre got %0b want 0", overflow); else n_pass++;
    w_data = 8'hCF;
    tick();
    wr = 1'b0;
    n_checks++; if (level !== 5'd16) $display("FAIL ovf_drop_level got %0d want 16", level); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got %0b want 1", overflow); else n_pass++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clr got %0b want 0", overflow); else n_pass++;
    wr = 1'b1; w_data = 8'hDD; ovf_clr = 1'b1;
    tick();
    wr = 1'b0; ovf_clr = 1'b0;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins got %0b want 1", overflow); else n_pass++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clr2 got %0b want 0", overflow); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    n_checks++; if (busy !== 1'b0 || level !== 5'd16) $display("FAIL fpp_idle got busy=%0b level=%0d want 0 16", busy, level); else n_pass++;
    wr = 1'b1; w_data = 8'hEE;
    tick();
    wr = 1'b0;
    n_checks++; if (level !== 5'd15) $display("FAIL fpp_level got %0d want 15", level); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL fpp_full got %0b want 0", full); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL fpp_overflow got %0b want 1", overflow); else n_pass++;
    n_checks++; if (tx_start !== 1'b1 || tx_din !== 8'hB0) $display("FAIL fpp_pop got start=%0b din=%h want 1 b0", tx_start, tx_din); else n_pass++;
  endtask

  task automatic test_watchdog();
    repeat (49) tick();
    n_checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) $display("FAIL wd_pre got err=%0b busy=%0b want 0 1", timeout_err, busy); else n_pass++;
    tick();
    n_checks++; if (timeout_err !== 1'b1) $display("FAIL wd_fire got %0b want 1", timeout_err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL wd_busy got %0b want 0", busy); else n_pass++;
    tick();
    n_checks++; if (tx_start !== 1'b1 || tx_din !== 8'hB1) $display("FAIL wd_next got start=%0b din=%h want 1 b1", tx_start, tx_din); else n_pass++;
    n_checks++; if (level !== 5'd14) $display("FAIL wd_level got %0d want 14", level); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (tx_start !== 1'b0) $display("FAIL arst_start got %0b want 0", tx_start); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL arst_busy got %0b want 0", busy); else n_pass++;
    n_checks++; if (empty !== 1'b1 || level !== 5'd0) $display("FAIL arst_fifo got empty=%0b level=%0d want 1 0", empty, level); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL arst_timeout got %0b want 0", timeout_err); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_watchdog();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
